// File: rtl/gate_bist_pkg.sv
// Shared definitions for the gate self-test sequencer: FSM encoding, vector count
// and the golden truth function for the AND/OR/NOT cells.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } bist_state_e;

  localparam int unsigned NUM_VECTORS = 4;

  // Result packed as {and, or, not}; the NOT cell only sees operand a.
  function automatic logic [2:0] expected_y(input logic a, input logic b);
    return {a & b, a | b, ~a};
  endfunction

endpackage

// File: rtl/gate_golden_model.sv
// Combinational reference for the gate cells: expected {and, or, not} for (a, b).
module gate_golden_model
  import gate_bist_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [2:0] y_exp
);

  always_comb begin
    y_exp = expected_y(a, b);
  end

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer: sweeps a/b through 00,01,10,11, holds each vector SETTLE_CYCLES
// clocks, then compares the gate outputs with the golden model and records mismatches.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  // start is a single-cycle request with no ready: it is accepted only when the
  // sequencer is idle and is silently dropped in every other state.
  input  logic             start,
  output logic             a_out,
  output logic             b_out,
  input  logic             y_and,
  input  logic             y_or,
  input  logic             y_not,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int IDX_W = $clog2(NUM_VECTORS);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_VECTORS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  bist_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0]       fail_q, fail_d;
  logic             pass_q, pass_d;

  logic [2:0]       y_exp;
  logic [2:0]       y_mis;
  logic [1:0]       mis_cnt;
  logic [ERR_W+1:0] err_sum;
  logic [ERR_W-1:0] err_sat;

  gate_golden_model u_golden (
    .a     (a_q),
    .b     (b_q),
    .y_exp (y_exp)
  );

  // Two extra bits so the running sum never overflows before clamping.
  always_comb begin
    y_mis   = y_exp ^ {y_and, y_or, y_not};
    mis_cnt = {1'b0, y_mis[0]} + {1'b0, y_mis[1]} + {1'b0, y_mis[2]};
    err_sum = {2'b00, err_q} + (ERR_W + 2)'(mis_cnt);
    err_sat = (err_sum > {2'b00, ERR_MAX}) ? ERR_MAX : err_sum[ERR_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fail_d  = fail_q;
    pass_d  = pass_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CHECK: begin
        err_d = err_sat;
        if (|y_mis) fail_d[idx_q] = 1'b1;
        if (idx_q == IDX_LAST) begin
          pass_d  = (err_sat == '0);
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Operands follow the vector being settled/checked and park at 00 otherwise.
    a_d = ((state_d == ST_SETTLE) || (state_d == ST_CHECK)) ? idx_d[1] : 1'b0;
    b_d = ((state_d == ST_SETTLE) || (state_d == ST_CHECK)) ? idx_d[0] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign busy      = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: emulated gate cells with per-vector fault masks, a
// directed table, and random fault patterns checked against a sweep-level model.
module tb_gate_bist_ctrl;

  localparam int S      = 2;
  localparam int SWEEP  = 4 * (S + 1);
  localparam int NCYC   = SWEEP + 4;

  logic clk;
  logic rst;

  logic       start1, a1, b1, yand1, yor1, ynot1, busy1, done1, pass1;
  logic [3:0] err1, fail1;
  logic       start2, a2, b2, yand2, yor2, ynot2, busy2, done2, pass2;
  logic [1:0] err2;
  logic [3:0] fail2;

  logic [3:0][2:0] flt1, flt2;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic            sel;
    logic [3:0][2:0] flt;
    int              restart_n;
    int              rst_n;
    logic [3:0]      exp_err;
    logic [3:0]      exp_fail;
    logic            exp_pass;
  } vec_t;

  vec_t tbl[10];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs and emulated gate cells ----------------
  function automatic logic [2:0] good_y(input logic a, input logic b);
    return {a & b, a | b, !a};
  endfunction

  assign {yand1, yor1, ynot1} = good_y(a1, b1) ^ flt1[{a1, b1}];
  assign {yand2, yor2, ynot2} = good_y(a2, b2) ^ flt2[{a2, b2}];

  gate_bist_ctrl #(.SETTLE_CYCLES(S), .ERR_W(4)) dut (
    .clk(clk), .rst(rst), .start(start1), .a_out(a1), .b_out(b1),
    .y_and(yand1), .y_or(yor1), .y_not(ynot1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .fail_vec(fail1)
  );

  gate_bist_ctrl #(.SETTLE_CYCLES(S), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a_out(a2), .b_out(b2),
    .y_and(yand2), .y_or(yor2), .y_not(ynot2), .busy(busy2), .done(done2),
    .pass(pass2), .err_count(err2), .fail_vec(fail2)
  );

  // ---------------- helpers ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [3:0] obs(input logic sel);
    return sel ? {busy2, done2, a2, b2} : {busy1, done1, a1, b1};
  endfunction

  function automatic logic [8:0] stat(input logic sel);
    return sel ? {pass2, fail2, 2'b00, err2} : {pass1, fail1, err1};
  endfunction

  task automatic set_start(input logic sel, input logic v);
    if (sel) start2 = v;
    else start1 = v;
  endtask

  // Sweep-level model: total flipped bits over the four vectors, clamped.
  task automatic model(input logic [3:0][2:0] flt, input int errw,
                       output logic [3:0] e_err, output logic [3:0] e_fail,
                       output logic e_pass);
    int total;
    int maxv;
    total = 0;
    for (int k = 0; k < 4; k++) begin
      total += $countones(flt[k]);
      e_fail[k] = |flt[k];
    end
    maxv   = (1 << errw) - 1;
    e_err  = 4'((total > maxv) ? maxv : total);
    e_pass = (total == 0);
  endtask

  // Per-cycle {busy, done, a, b} after the start edge E; n = cycles since E.
  task automatic build_expect(input int rst_n);
    exp_q.delete();
    for (int n = 0; n < NCYC; n++) begin
      logic [3:0] e;
      int k;
      k = n / (S + 1);
      if (rst_n >= 0 && n > rst_n) e = 4'b0000;
      else if (n < SWEEP) e = {1'b1, 1'b0, 2'(k)};
      else if (n == SWEEP) e = 4'b0100;
      else e = 4'b0000;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_sweep(input vec_t v);
    if (v.sel) flt2 = v.flt;
    else flt1 = v.flt;
    build_expect(v.rst_n);
    @(negedge clk);
    set_start(v.sel, 1'b1);
    for (int n = 0; n < NCYC; n++) begin
      logic [3:0] e;
      @(negedge clk);
      if (n == 0) set_start(v.sel, 1'b0);
      e = exp_q.pop_front();
      check($sformatf("cycle%0d_busy_done_a_b", n), 32'(obs(v.sel)), 32'(e));
      if (v.rst_n < 0 && (n == SWEEP || n == NCYC - 1))
        check($sformatf("status_n%0d", n), 32'(stat(v.sel)),
              32'({v.exp_pass, v.exp_fail, v.exp_err}));
      if (v.rst_n >= 0 && n == v.rst_n + 1) begin
        check("status_after_rst", 32'(stat(v.sel)), 32'd0);
        rst = 1'b0;
      end
      if (n == v.restart_n) set_start(v.sel, 1'b1);
      if (n == v.restart_n + 1) set_start(v.sel, 1'b0);
      if (n == v.rst_n) rst = 1'b1;
    end
    set_start(v.sel, 1'b0);
    rst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t rv;
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0;
    flt1 = '0; flt2 = '0;

    tbl[0] = '{1'b0, 12'h000, -1, -1, 4'd0,  4'b0000, 1'b1};
    tbl[1] = '{1'b0, {3'b100, 3'b000, 3'b000, 3'b000}, -1, -1, 4'd1, 4'b1000, 1'b0};
    tbl[2] = '{1'b0, {3'b001, 3'b001, 3'b001, 3'b001}, -1, -1, 4'd4, 4'b1111, 1'b0};
    tbl[3] = '{1'b0, 12'h000, 3, -1, 4'd0,  4'b0000, 1'b1};
    tbl[4] = '{1'b0, 12'h000, SWEEP, -1, 4'd0, 4'b0000, 1'b1};
    tbl[5] = '{1'b0, 12'hfff, -1, 6, 4'd0,  4'b0000, 1'b0};
    tbl[6] = '{1'b0, 12'h000, -1, -1, 4'd0,  4'b0000, 1'b1};
    tbl[7] = '{1'b1, 12'hfff, -1, -1, 4'd3,  4'b1111, 1'b0};
    tbl[8] = '{1'b1, 12'h000, -1, -1, 4'd0,  4'b0000, 1'b1};
    tbl[9] = '{1'b0, 12'hfff, -1, -1, 4'd12, 4'b1111, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_obs_dut", 32'(obs(1'b0)), 32'd0);
    check("reset_stat_dut", 32'(stat(1'b0)), 32'd0);
    check("reset_obs_dut2", 32'(obs(1'b1)), 32'd0);
    check("reset_stat_dut2", 32'(stat(1'b1)), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_sweep(tbl[i]);

    for (int i = 0; i < 24; i++) begin
      rv.sel = 1'($urandom_range(0, 1));
      rv.flt = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
      rv.restart_n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, SWEEP)) : -1;
      rv.rst_n = -1;
      model(rv.flt, rv.sel ? 2 : 4, rv.exp_err, rv.exp_fail, rv.exp_pass);
      run_sweep(rv);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
